// File: rtl/lvds_ddr_framed_rx.sv
// LVDS DDR receive path: differential input buffer and IDDR feed a 2-bit/cycle
// deserialiser that hunts for a sync byte and holds frame lock with hysteresis.
module lvds_ddr_framed_rx #(
   parameter logic [7:0] SYNC_BYTE   = 8'hA5,
   parameter int         FRAME_LEN   = 16,
   parameter int         LOCK_COUNT  = 4,
   parameter int         LOSS_COUNT  = 4,
   parameter int         STARTUP_CYC = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        tlvds_p,
   input  logic        tlvds_n,
   output logic [7:0]  rx_data,
   output logic        rx_valid,
   output logic        rx_sof,
   output logic        locked,
   output logic [15:0] sync_err_cnt
);
   localparam int IW = $clog2(FRAME_LEN);
   localparam int GW = $clog2(LOCK_COUNT + 1);
   localparam int MW = $clog2(LOSS_COUNT + 1);
   localparam int SW = (STARTUP_CYC > 1) ? $clog2(STARTUP_CYC) : 1;

   typedef enum logic [1:0] {ST_STARTUP, ST_HUNT, ST_VERIFY, ST_LOCKED} state_t;
   state_t state_q, state_d;

   logic          din, d_fall, q0, q1;
   logic [8:0]    sr;          // only the nine newest bits are ever examined
   logic [SW-1:0] su_cnt;
   logic [1:0]    cyc4;
   logic [IW-1:0] byte_idx, nidx;
   logic [GW-1:0] good;
   logic [MW-1:0] miss;
   logic          phase, hit0, hit1, bnd, at_sync, sync_ok;
   logic [7:0]    byte_w;

   // Differential buffer and IDDR: Q0 is the bit sampled on the falling edge.
   assign din = tlvds_p & ~tlvds_n;

   always_ff @(negedge clk) d_fall <= din;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         q0 <= 1'b0;
         q1 <= 1'b0;
      end else begin
         q0 <= d_fall;
         q1 <= din;
      end
   end

   assign hit0    = (sr[7:0] == SYNC_BYTE);
   assign hit1    = (sr[8:1] == SYNC_BYTE);
   assign byte_w  = phase ? sr[8:1] : sr[7:0];
   assign bnd     = (cyc4 == 2'd3);
   assign nidx    = (byte_idx == IW'(FRAME_LEN - 1)) ? '0 : byte_idx + 1'b1;
   assign at_sync = (nidx == '0);
   assign sync_ok = (byte_w == SYNC_BYTE);
   assign locked  = (state_q == ST_LOCKED);

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_STARTUP: if (su_cnt == SW'(STARTUP_CYC - 1)) state_d = ST_HUNT;
         ST_HUNT:    if (hit0 || hit1) state_d = (LOCK_COUNT == 1) ? ST_LOCKED : ST_VERIFY;
         ST_VERIFY:
            if (bnd && at_sync) begin
               if (!sync_ok)                         state_d = ST_HUNT;
               else if (good == GW'(LOCK_COUNT - 1)) state_d = ST_LOCKED;
            end
         ST_LOCKED:
            if (bnd && at_sync && !sync_ok && miss == MW'(LOSS_COUNT - 1)) state_d = ST_HUNT;
         default: state_d = ST_STARTUP;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_STARTUP;
         sr           <= '0;
         su_cnt       <= '0;
         cyc4         <= '0;
         byte_idx     <= '0;
         good         <= '0;
         miss         <= '0;
         phase        <= 1'b0;
         rx_data      <= '0;
         rx_valid     <= 1'b0;
         rx_sof       <= 1'b0;
         sync_err_cnt <= '0;
      end else begin
         state_q  <= state_d;
         sr       <= {sr[6:0], q0, q1};
         cyc4     <= cyc4 + 2'd1;
         rx_valid <= 1'b0;
         rx_sof   <= 1'b0;
         unique case (state_q)
            ST_STARTUP: su_cnt <= su_cnt + 1'b1;
            ST_HUNT:
               if (hit0 || hit1) begin
                  phase    <= ~hit0;
                  cyc4     <= '0;
                  byte_idx <= '0;
                  good     <= GW'(1);
                  miss     <= '0;
               end
            ST_VERIFY, ST_LOCKED:
               if (bnd) begin
                  byte_idx <= nidx;
                  if (at_sync) begin
                     if (state_q == ST_VERIFY) begin
                        if (sync_ok) good <= good + 1'b1;
                     end else if (sync_ok) begin
                        miss <= '0;
                     end else begin
                        miss <= miss + 1'b1;
                        if (sync_err_cnt != 16'hFFFF) sync_err_cnt <= sync_err_cnt + 16'd1;
                     end
                  end else if (state_q == ST_LOCKED) begin
                     rx_data  <= byte_w;
                     rx_valid <= 1'b1;
                     rx_sof   <= (nidx == IW'(1));
                  end
               end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_lvds_ddr_framed_rx.sv
// Scoreboard bench for lvds_ddr_framed_rx: a byte-level model of the framing rules
// predicts every payload strobe and lock change for directed and random bit streams.
module tb_lvds_ddr_framed_rx;
   localparam logic [7:0] SYNC  = 8'hA5;
   localparam int         FLEN  = 16;
   localparam int         LOCKN = 4;
   localparam int         LOSSN = 4;
   localparam int         SCYC  = 8;

   logic        clk = 1'b0, rst_n = 1'b0, tlvds_p = 1'b0, tlvds_n = 1'b1;
   logic [7:0]  rx_data;
   logic        rx_valid, rx_sof, locked;
   logic [15:0] sync_err_cnt;

   lvds_ddr_framed_rx #(
      .SYNC_BYTE(SYNC), .FRAME_LEN(FLEN), .LOCK_COUNT(LOCKN),
      .LOSS_COUNT(LOSSN), .STARTUP_CYC(SCYC)
   ) dut (
      .clk(clk), .rst_n(rst_n), .tlvds_p(tlvds_p), .tlvds_n(tlvds_n),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_sof(rx_sof),
      .locked(locked), .sync_err_cnt(sync_err_cnt)
   );

   always #5 clk = ~clk;

   typedef struct { int at; logic [7:0] data; logic sof; logic [15:0] err; } bev_t;
   typedef struct { int at; logic val; } lev_t;

   bev_t        bq[$];
   lev_t        lq[$];
   bit          stim[$];
   int          checks = 0, errors = 0, cyc = -2;
   logic        exp_lock, prev_lock;
   logic [15:0] exp_err;

   // Clock edges counted from reset release; edge 0 is the first edge with rst_n high.
   always @(posedge clk) cyc <= rst_n ? cyc + 1 : -1;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Byte on the wire whose last (LSB) bit is stream bit eb; bits before the stream are 0.
   function automatic logic [7:0] win(input int eb);
      logic [7:0] v;
      int i;
      v = '0;
      for (int k = 7; k >= 0; k--) begin
         i = eb - k;
         v = {v[6:0], (i >= 0 && i < stim.size()) ? logic'(stim[i]) : 1'b0};
      end
      return v;
   endfunction

   // Stream pair p reaches the comparators at edge p+3; the hunt opens at edge SCYC.
   task automatic build_model(input int np);
      int p, eb, pe, idx, good, miss, last;
      logic lk;
      logic [7:0] b;
      bq.delete();
      lq.delete();
      exp_err = '0;
      lk = 1'b0;
      last = np - 3;
      p = SCYC - 3;
      pe = p;
      while (p <= last) begin
         eb = -1;
         while (p <= last && eb < 0) begin
            if (win(2*p + 1) == SYNC)  eb = 2*p + 1;
            else if (win(2*p) == SYNC) eb = 2*p;
            p++;
         end
         if (eb < 0) break;
         good = 1; miss = 0; idx = 0;
         if (good == LOCKN) begin lk = 1'b1; lq.push_back(lev_t'{eb/2 + 3, 1'b1}); end
         forever begin
            eb += 8;
            pe = eb / 2;
            if (pe > last) break;
            idx = (idx + 1) % FLEN;
            b = win(eb);
            if (idx == 0) begin
               if (!lk) begin
                  if (b != SYNC) break;
                  good++;
                  if (good == LOCKN) begin lk = 1'b1; lq.push_back(lev_t'{pe + 3, 1'b1}); end
               end else if (b == SYNC) begin
                  miss = 0;
               end else begin
                  if (exp_err != 16'hFFFF) exp_err++;
                  miss++;
                  if (miss == LOSSN) begin lk = 1'b0; lq.push_back(lev_t'{pe + 3, 1'b0}); break; end
               end
            end else if (lk) begin
               bq.push_back(bev_t'{pe + 3, b, idx == 1, exp_err});
            end
         end
         p = pe + 1;
      end
      exp_lock = lk;
   endtask

   task automatic put_byte(input logic [7:0] v);
      for (int k = 7; k >= 0; k--) stim.push_back(v[k]);
   endtask

   task automatic put_zeros(input int n);
      repeat (n) stim.push_back(1'b0);
   endtask

   task automatic put_frame(input logic [7:0] s, input bit rnd, input int nbytes);
      put_byte(s);
      for (int i = 1; i < nbytes; i++) put_byte(rnd ? 8'($urandom) : 8'(i));
   endtask

   // Entered just after an edge that sampled rst_n low; leaves the same way.
   task automatic run_stream(input string nm);
      int np;
      if (stim.size() % 2 != 0) stim.push_back(1'b0);
      np = stim.size() / 2;
      build_model(np);
      chk({nm, ":reset_outputs"},
          32'({rx_data, rx_valid, rx_sof, locked, sync_err_cnt}), 32'd0);
      rst_n = 1'b1;
      for (int p = 0; p < np; p++) begin
         @(posedge clk); #1;
         tlvds_p = stim[2*p];     tlvds_n = ~stim[2*p];
         @(negedge clk); #1;
         tlvds_p = stim[2*p + 1]; tlvds_n = ~stim[2*p + 1];
      end
      @(posedge clk); #1;
      rst_n = 1'b0; tlvds_p = 1'b0; tlvds_n = 1'b1;
      @(negedge clk); #1;
      chk({nm, ":bytes_left"}, 32'(bq.size()), 32'd0);
      chk({nm, ":lock_events_left"}, 32'(lq.size()), 32'd0);
      chk({nm, ":final_locked"}, 32'(locked), 32'(exp_lock));
      chk({nm, ":final_sync_err_cnt"}, 32'(sync_err_cnt), 32'(exp_err));
      @(posedge clk); #1;
      stim.delete();
   endtask

   // Monitor: pops the scoreboard on every strobe and every change of locked.
   initial begin
      bev_t e;
      lev_t l;
      forever begin
         @(negedge clk);
         if (cyc >= 0) begin
            if (rx_valid === 1'b1) begin
               if (bq.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL spurious_rx_valid: got rx_valid=1 rx_data=%h expected no strobe (cycle %0d)",
                           rx_data, cyc);
               end else begin
                  e = bq.pop_front();
                  chk("rx_valid_cycle", cyc, e.at);
                  chk("rx_data", 32'(rx_data), 32'(e.data));
                  chk("rx_sof", 32'(rx_sof), 32'(e.sof));
                  chk("locked_with_valid", 32'(locked), 32'd1);
                  chk("sync_err_cnt", 32'(sync_err_cnt), 32'(e.err));
               end
            end else if (rx_sof !== 1'b0) begin
               checks++; errors++;
               $display("FAIL lone_rx_sof: got rx_sof=%b expected 0 (cycle %0d)", rx_sof, cyc);
            end
            if (locked !== prev_lock) begin
               if (lq.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL spurious_lock_change: got locked=%b expected %b (cycle %0d)",
                           locked, prev_lock, cyc);
               end else begin
                  l = lq.pop_front();
                  chk("lock_cycle", cyc, l.at);
                  chk("lock_value", 32'(locked), 32'(l.val));
               end
            end
         end
         prev_lock = locked;
      end
   end

   initial begin
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      // phase 0 lock; the stream ends mid-frame so the next run resets a locked receiver
      put_zeros(32); repeat (8) put_frame(SYNC, 1'b0, FLEN); put_frame(SYNC, 1'b0, 8);
      run_stream("phase0");
      put_zeros(32); repeat (8) put_frame(SYNC, 1'b0, FLEN); put_frame(SYNC, 1'b0, 8);
      run_stream("relock_after_reset");
      put_zeros(33); repeat (8) put_frame(SYNC, 1'b0, FLEN);
      run_stream("phase1");
      // one isolated bad sync, later four in a row, then re-lock
      put_zeros(32);
      for (int f = 0; f < 19; f++)
         put_frame((f == 6 || (f >= 9 && f <= 12)) ? 8'h5A : SYNC, 1'b0, FLEN);
      put_frame(SYNC, 1'b0, 8);
      run_stream("bad_sync");
      // false sync in leading data before the true frames
      put_byte(8'h00); put_byte(8'h00); put_byte(8'h00); put_byte(SYNC);
      put_byte(8'h07); put_byte(8'h08); put_byte(8'h09);
      repeat (7) put_frame(SYNC, 1'b0, FLEN);
      run_stream("false_sync");
      // sync byte inside the settle window
      put_zeros(2); put_byte(SYNC); put_zeros(30);
      repeat (6) put_frame(SYNC, 1'b0, FLEN);
      run_stream("startup_sync");
      for (int r = 0; r < 8; r++) begin
         put_zeros($urandom_range(0, 40));
         repeat ($urandom_range(0, 5)) put_byte(8'($urandom));
         repeat ($urandom_range(6, 10))
            put_frame(($urandom_range(0, 7) == 0) ? 8'($urandom) : SYNC, 1'b1, FLEN);
         put_frame(SYNC, 1'b1, $urandom_range(2, FLEN - 1));
         run_stream("random");
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
